load_arbiter: RTL
=================

Name: load_arbiter

Overview:
- Shares the tiny processor's serial load/run channel (mosi_out, mode_out, done_in) between NUM_REQ independent requesters.
- Each requester asks for one of three transactions:
  - one imem byte write;
  - one dmem byte write;
  - one run command.
- A round-robin arbiter grants one requester at a time, serializes the frame, and returns a one-cycle ack.
- Sits between host-side loaders (driver-style sequencers, debug ports) and the processor's load interface.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
GAP_CYCLES, 2, idle cycles with mode_out=00 after each frame (legal 1..15)
TIMEOUT_CYCLES, 1024, RUN watchdog limit (used only with LOAD_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
req  in  NUM_REQ  per-requester request, held until its ack
cmd  in  2*NUM_REQ  per-requester command: 01 imem write, 10 dmem write, 11 run, 00 no-op
addr  in  4*NUM_REQ  per-requester target address
wdata  in  8*NUM_REQ  per-requester write byte
ack  out  NUM_REQ  one-hot, one-cycle completion pulse
busy  out  1  high whenever FSM is not IDLE
mosi_out  out  1  serial frame data to processor
mode_out  out  2  processor mode: 00 idle, 01 imem load, 10 dmem load, 11 run
done_in  in  1  processor completion flag (run finished)
timeout_err  out  1  sticky RUN watchdog error flag

Behaviour:
- States: IDLE, SEND, GAP, RUN, DONE. All outputs registered.
- Reset values (apply immediately, no clock edge needed):
  - state IDLE; ack 0; busy 0; mosi_out 0; mode_out 00; timeout_err 0.
  - round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- In-flight transaction at reset: abandoned, no ack.
- IDLE: req sampled only here. Arbitration:
  - Search starts at pointer+1, wraps mod NUM_REQ.
  - Winner's cmd/addr/wdata are captured into shadow registers; pointer <= winner.
  - Next state: cmd 01/10 -> SEND; 11 -> RUN; 00 -> DONE.
  - Inputs may change after grant; only shadow registers are used.
- SEND:
  - frame[12:0] = {1'b0, wdata[7:0], addr[3:0]}, transmitted LSB first (bit 0 first).
  - Each bit held exactly 2 cycles; SEND lasts exactly 26 cycles.
  - mode_out = shadow cmd for all 26 cycles; mosi_out = frame[bitcnt].
  - Uses a 4-bit bit counter and a 1-bit phase toggle.
  - After the 2nd cycle of bit 12 -> GAP.
- GAP: mode_out 00, mosi_out 0, for exactly GAP_CYCLES cycles, then -> DONE.
- RUN:
  - mode_out 11, mosi_out 0.
  - done_in ignored during the first 2 RUN cycles (processor mode settle).
  - From the 3rd cycle on, done_in sampled high -> DONE; mode_out returns 00 in DONE.
- DONE:
  - Exactly 1 cycle; ack[winner] = 1, all other ack bits 0; mode_out 00; -> IDLE.
  - Requester deasserts req at the edge ending DONE. req still high in the following IDLE is a new request.
- Latency, req sampled in IDLE at edge T:
  - mode_out nonzero from T+1.
  - write ack high in cycle T+27+GAP_CYCLES.
  - no-op ack at T+1.
- busy = (state != IDLE), registered alongside state.
- Simultaneous requests: strict round-robin, so no requester waits more than NUM_REQ-1 transactions.
- done_in high outside RUN: ignored.

Optional Feature:
- Macro LOAD_ARB_TIMEOUT_EN.
- Defined:
  - A RUN cycle counter clears on entry to RUN.
  - If the counter reaches TIMEOUT_CYCLES without a qualifying done_in: set timeout_err (sticky until rst), force mode_out 00, go to DONE and ack the winner normally.
- Undefined:
  - No counter logic.
  - timeout_err tied 0.
  - RUN waits indefinitely for done_in.

Test Plan:
1. Single write: req[0], cmd=01, addr=5, wdata=A3 -> mode_out=01 for 26 cycles; mosi_out pairs 1,0,1,0,1,1,0,0,0,1,0,1,0; 2 gap cycles at 00; ack[0] high one cycle at T+29; busy low the cycle after.
2. Arbitration: req=1111 with all cmd=10 held until ack -> grant order 0,1,2,3. Then req[0] and req[2] together -> order 0 then 2. Exactly one ack bit per DONE.
3. Run: req[1] cmd=11; done_in pulsed in RUN cycle 1 -> ignored. done_in high in RUN cycle 10 -> DONE next cycle, ack[1], mode_out 11 -> 00.
4. Async reset mid-SEND (bit 6), asserted between clock edges -> mode_out 00, mosi_out 0, busy 0 immediately; no ack. Afterwards req[3] alone wins; with simultaneous req[0]/req[3], req[0] wins first.
5. No-op: req[2] cmd=00 -> ack[2] at T+1, mode_out stays 00, mosi_out stays 0.
6. With LOAD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, done_in held 0 during run -> mode_out 00 after 16 RUN cycles, ack issued, timeout_err 1 until rst.

Source files
------------

// File: rtl/load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : load_arbiter
// Brief    : Round-robin arbiter that serializes imem/dmem byte writes and run
//            commands from NUM_REQ requesters onto the processor load channel.
//            Optional RUN watchdog is enabled by defining LOAD_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module load_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   cmd,
    input  logic [4*NUM_REQ-1:0]   addr,
    input  logic [8*NUM_REQ-1:0]   wdata,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic                   mosi_out,
    output logic [1:0]             mode_out,
    input  logic                   done_in,
    output logic                   timeout_err
);

    localparam int                 c_PTR_W    = $clog2(NUM_REQ);
    localparam logic [c_PTR_W-1:0] c_PTR_MAX  = c_PTR_W'(NUM_REQ - 1);
    localparam logic [c_PTR_W:0]   c_NUM      = (c_PTR_W + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);
    localparam logic [3:0]         c_GAP_LAST = 4'(GAP_CYCLES - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_SEND = 3'd1;
    localparam logic [2:0] c_GAP  = 3'd2;
    localparam logic [2:0] c_RUN  = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 15 ||
        TIMEOUT_CYCLES < 3) begin : g_bad_params
        $error("load_arbiter: parameter out of legal range");
    end

    logic [2:0]         r_state;
    logic               r_busy;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_mosi;
    logic [1:0]         r_mode;
    logic [c_PTR_W-1:0] r_ptr;
    logic [3:0]         r_addr;
    logic [7:0]         r_wdata;
    logic [3:0]         r_bitcnt;
    logic               r_phase;
    logic [3:0]         r_gap_cnt;
    logic [1:0]         r_run_cnt;

    logic               w_found;
    logic [c_PTR_W-1:0] w_win;
    logic [c_PTR_W:0]   w_sum;
    logic [1:0]         w_cmd_sel;
    logic [3:0]         w_addr_sel;
    logic [7:0]         w_wdata_sel;
    logic [12:0]        w_frame;
    logic               w_run_done;

    // Search begins just after the last winner and wraps modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_sum   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (c_PTR_W + 1)'(i);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            if (!w_found && req[w_sum[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_cmd_sel   = 2'b00;
        w_addr_sel  = 4'h0;
        w_wdata_sel = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win == c_PTR_W'(k)) begin
                w_cmd_sel   = cmd[2*k +: 2];
                w_addr_sel  = addr[4*k +: 4];
                w_wdata_sel = wdata[8*k +: 8];
            end
        end
    end

    assign w_frame    = {1'b0, r_wdata, r_addr};
    // The first two RUN cycles give the processor time to settle its mode.
    assign w_run_done = (r_run_cnt == 2'd2) && done_in;

`ifdef LOAD_ARB_TIMEOUT_EN
    localparam int             c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_busy    <= 1'b0;
            r_ack     <= '0;
            r_mosi    <= 1'b0;
            r_mode    <= 2'b00;
            r_ptr     <= c_PTR_MAX;
            r_addr    <= 4'h0;
            r_wdata   <= 8'h00;
            r_bitcnt  <= 4'd0;
            r_phase   <= 1'b0;
            r_gap_cnt <= 4'd0;
            r_run_cnt <= 2'd0;
`ifdef LOAD_ARB_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_ptr     <= w_win;
                        r_addr    <= w_addr_sel;
                        r_wdata   <= w_wdata_sel;
                        r_busy    <= 1'b1;
                        r_bitcnt  <= 4'd0;
                        r_phase   <= 1'b0;
                        r_run_cnt <= 2'd0;
`ifdef LOAD_ARB_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                        case (w_cmd_sel)
                            2'b01, 2'b10: begin
                                r_state <= c_SEND;
                                r_mode  <= w_cmd_sel;
                                r_mosi  <= w_addr_sel[0];
                            end
                            2'b11: begin
                                r_state <= c_RUN;
                                r_mode  <= 2'b11;
                                r_mosi  <= 1'b0;
                            end
                            default: begin
                                r_state <= c_DONE;
                                r_ack   <= c_ONE << w_win;
                            end
                        endcase
                    end
                end
                c_SEND: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (r_bitcnt == 4'd12) begin
                            r_state   <= c_GAP;
                            r_mode    <= 2'b00;
                            r_mosi    <= 1'b0;
                            r_gap_cnt <= 4'd0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            r_mosi   <= w_frame[r_bitcnt + 4'd1];
                        end
                    end
                end
                c_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= c_DONE;
                        r_ack   <= c_ONE << r_ptr;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                c_RUN: begin
                    if (r_run_cnt != 2'd2) begin
                        r_run_cnt <= r_run_cnt + 2'd1;
                    end
                    if (w_run_done) begin
                        r_state <= c_DONE;
                        r_mode  <= 2'b00;
                        r_ack   <= c_ONE << r_ptr;
                    end
`ifdef LOAD_ARB_TIMEOUT_EN
                    else if (r_to_cnt == c_TO_LAST) begin
                        r_state       <= c_DONE;
                        r_mode        <= 2'b00;
                        r_ack         <= c_ONE << r_ptr;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_mode  <= 2'b00;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign busy     = r_busy;
    assign mosi_out = r_mosi;
    assign mode_out = r_mode;

endmodule
`default_nettype wire
